// File: rtl/pxs_stream_pkg.sv
// Shared RGB stream field positions and font ROM geometry for the pxs painters.
// No logic; no flow control.
package pxs_stream_pkg;

    localparam int ACTIVE = 0;
    localparam int VS     = 1;
    localparam int HS     = 2;
    localparam int YC_LO  = 3;
    localparam int YC_HI  = 12;
    localparam int XC_LO  = 13;
    localparam int XC_HI  = 22;
    localparam int RGB_LO = 23;
    localparam int RGB_HI = 25;
    localparam int STR_W  = 26;

    localparam int GW     = 8;
    localparam int GH     = 8;
    localparam int GC     = 16;
    localparam int GR     = 16;
    localparam int FW     = GC * GH;
    localparam int ROM_AW = $clog2(GC * GR * GH);

    // Glyph table is 16 codes wide; each table row of 16 glyphs spans FW bytes.
    function automatic logic [ROM_AW-1:0] font_addr(input logic [7:0] code, input logic [2:0] gy);
        font_addr = ROM_AW'(code[7:4]) * ROM_AW'(FW) + ROM_AW'(gy) * ROM_AW'(GC) + ROM_AW'(code[3:0]);
    endfunction

endpackage

// File: rtl/pxs_char_buffer.sv
// Character line store: one write port, one registered read-first read port; 1-cycle read latency.
// No backpressure; writes to cells beyond NCHARS are dropped.
module pxs_char_buffer #(
    parameter int NCHARS = 16,
    parameter int CW     = 4
) (
    input  logic          px_clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [CW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam logic [CW:0] NC = (CW+1)'(NCHARS);

    logic [7:0] cells [NCHARS];

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHARS; i++) begin
                cells[i] <= 8'h20;
            end
            rd_data <= 8'h00;
        end else begin
            if (wr_en && ({1'b0, wr_addr} < NC)) begin
                cells[wr_addr] <= wr_data;
            end
            // Out-of-range indices only occur for pixels outside the box.
            if ({1'b0, rd_addr} < NC) begin
                rd_data <= cells[rd_addr];
            end else begin
                rd_data <= 8'h20;
            end
        end
    end

endmodule

// File: rtl/pxs_text_line.sv
// Overlays a scaled line of NCHARS glyphs with a blinking cursor on the RGB stream; 5-cycle latency.
// No backpressure: one pixel in and one pixel out every px_clk.
module pxs_text_line
    import pxs_stream_pkg::*;
#(
    parameter int          NCHARS      = 16,
    parameter int          SCALE_LOG2  = 1,
    parameter logic [2:0]  COLOR_FG    = 3'b010,
    parameter logic [2:0]  COLOR_BG    = 3'b001,
    parameter int          TRANSPARENT = 1,
    parameter int          BLINK_LOG2  = 5,
    localparam int         CW          = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
    input  logic              px_clk,
    input  logic              reset,
    input  logic [25:0]       RGBStr_i,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              cursor_en,
    input  logic [CW-1:0]     cursor_pos,
    output logic [10:0]       addr_rom,
    input  logic [0:7]        gline,
    output logic [25:0]       RGBStr_o
);

    // Bounds are compared wider than the 10-bit screen so a box past x=1023 clips.
    localparam int            BSW = 16;
    localparam logic [BSW-1:0] BW = BSW'(NCHARS * (GW << SCALE_LOG2));
    localparam logic [BSW-1:0] BH = BSW'(GH << SCALE_LOG2);
    localparam logic [CW:0]    NC = (CW+1)'(NCHARS);

    logic [9:0]     xc;
    logic [9:0]     yc;
    logic [9:0]     dx;
    logic [9:0]     dy;
    logic [9:0]     dx_cell;
    logic           in_box;
    logic           cur_hit;
    logic [BSW-1:0] x_ext;
    logic [BSW-1:0] y_ext;
    logic [BSW-1:0] px_ext;
    logic [BSW-1:0] py_ext;

    logic [BLINK_LOG2:0] blink_cnt;
    logic                vs_q;
    logic                blink_on;

    assign xc      = RGBStr_i[XC_HI:XC_LO];
    assign yc      = RGBStr_i[YC_HI:YC_LO];
    assign dx      = xc - pos_x;
    assign dy      = yc - pos_y;
    assign dx_cell = dx >> (3 + SCALE_LOG2);
    assign x_ext   = BSW'(xc);
    assign y_ext   = BSW'(yc);
    assign px_ext  = BSW'(pos_x);
    assign py_ext  = BSW'(pos_y);

    assign in_box = RGBStr_i[ACTIVE]
                 && (x_ext >= px_ext) && (x_ext < px_ext + BW)
                 && (y_ext >= py_ext) && (y_ext < py_ext + BH);

    assign blink_on = blink_cnt[BLINK_LOG2];
    assign cur_hit  = cursor_en && blink_on && ({1'b0, cursor_pos} < NC)
                   && (dx_cell == 10'(cursor_pos));

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            vs_q      <= 1'b0;
            blink_cnt <= '0;
        end else begin
            vs_q <= RGBStr_i[VS];
            if (RGBStr_i[VS] && !vs_q) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    logic [STR_W-1:0] s1_str, s2_str, s3_str, s4_str;
    logic             s1_in, s2_in, s3_in, s4_in;
    logic             s1_cur, s2_cur, s3_cur, s4_cur;
    logic [2:0]       s1_gx, s2_gx, s3_gx, s4_gx;
    logic [2:0]       s1_gy, s2_gy;
    logic [CW-1:0]    s1_idx;
    logic [7:0]       s2_code;

    pxs_char_buffer #(
        .NCHARS (NCHARS),
        .CW     (CW)
    ) u_buf (
        .px_clk  (px_clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (s1_idx),
        .rd_data (s2_code)
    );

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            s1_str <= '0; s1_in <= 1'b0; s1_cur <= 1'b0; s1_gx <= '0; s1_gy <= '0; s1_idx <= '0;
            s2_str <= '0; s2_in <= 1'b0; s2_cur <= 1'b0; s2_gx <= '0; s2_gy <= '0;
            s3_str <= '0; s3_in <= 1'b0; s3_cur <= 1'b0; s3_gx <= '0;
            s4_str <= '0; s4_in <= 1'b0; s4_cur <= 1'b0; s4_gx <= '0;
            addr_rom <= '0;
        end else begin
            s1_str <= RGBStr_i;
            s1_in  <= in_box;
            s1_cur <= cur_hit;
            s1_idx <= CW'(dx_cell);
            s1_gx  <= 3'(dx >> SCALE_LOG2);
            s1_gy  <= 3'(dy >> SCALE_LOG2);

            s2_str <= s1_str;
            s2_in  <= s1_in;
            s2_cur <= s1_cur;
            s2_gx  <= s1_gx;
            s2_gy  <= s1_gy;

            s3_str <= s2_str;
            s3_in  <= s2_in;
            s3_cur <= s2_cur;
            s3_gx  <= s2_gx;
            // Holding the address outside the box keeps the ROM bus quiet.
            if (s2_in) begin
                addr_rom <= font_addr(s2_code, s2_gy);
            end

            s4_str <= s3_str;
            s4_in  <= s3_in;
            s4_cur <= s3_cur;
            s4_gx  <= s3_gx;
        end
    end

    logic       px_bit;
    logic [2:0] rgb_out;

    always_comb begin
        px_bit  = gline[s4_gx] ^ s4_cur;
        rgb_out = s4_str[RGB_HI:RGB_LO];
        if (s4_in) begin
            if (px_bit) begin
                rgb_out = COLOR_FG;
            end else if (TRANSPARENT == 0) begin
                rgb_out = COLOR_BG;
            end
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            RGBStr_o <= '0;
        end else begin
            RGBStr_o <= {rgb_out, s4_str[RGB_LO-1:0]};
        end
    end

endmodule
